// File: rtl/mlp_wload_ctrl_if.sv
// Weight-stream and MLP weight/set-register bus between the host DMA, the loader and the MLP top.
// The master modport is the environment side. The slave modport is the loader side.
interface mlp_wload_ctrl_if;
    logic        s_wtvalid;
    logic        s_wtready;
    logic [15:0] s_wtdata;
    logic        s_wtlast;
    logic [31:0] w_tdata;
    logic [15:0] set_cur;
    logic        set_en;
    logic [15:0] set_in;

    modport master (
        output s_wtvalid, s_wtdata, s_wtlast, set_cur,
        input  s_wtready, w_tdata, set_en, set_in
    );

    modport slave (
        input  s_wtvalid, s_wtdata, s_wtlast, set_cur,
        output s_wtready, w_tdata, set_en, set_in
    );
endinterface

// File: rtl/mlp_wload_ctrl.sv
// Weight-load sequencer: tags a flat weight stream with a layer one-hot and an in-layer index.
// It also brackets the load with arm/disarm writes to bit 1 of the MLP set register.
module mlp_wload_ctrl #(
    parameter int unsigned N_L0 = 15,
    parameter int unsigned N_L1 = 24,
    parameter int unsigned N_L2 = 24,
    parameter int unsigned N_L3 = 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic                  abort,
    mlp_wload_ctrl_if.slave       wl,
    output logic                  act_enable,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            err_code
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StArm    = 3'd1;
    localparam logic [2:0] StLoad   = 3'd2;
    localparam logic [2:0] StDisarm = 3'd3;
    localparam logic [2:0] StDone   = 3'd4;

    localparam logic [15:0] WrEnBit = 16'h0002;

    logic [2:0]  state_q, state_d;
    logic [1:0]  layer_q, layer_d;
    logic [6:0]  idx_q, idx_d;
    logic [31:0] w_tdata_q, w_tdata_d;
    logic [15:0] set_in_q, set_in_d;
    logic        err_q, err_d;
    logic [1:0]  err_code_q, err_code_d;

    logic        ready;
    logic        hs;
    logic        set_en;
    logic [6:0]  idx_lim;
    logic        final_word;
    logic [3:0]  onehot;

    always_comb begin
        case (layer_q)
            2'd0:    idx_lim = 7'(N_L0 - 1);
            2'd1:    idx_lim = 7'(N_L1 - 1);
            2'd2:    idx_lim = 7'(N_L2 - 1);
            default: idx_lim = 7'(N_L3 - 1);
        endcase
    end

    // Abort blocks the handshake in the same cycle, so no word slips past a cancel.
    assign ready      = (state_q == StLoad) && !abort;
    assign hs         = wl.s_wtvalid && ready;
    assign final_word = (layer_q == 2'd3) && (idx_q == idx_lim);
    assign onehot     = 4'b0001 << layer_q;

    always_comb begin
        state_d    = state_q;
        layer_d    = layer_q;
        idx_d      = idx_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        w_tdata_d  = '0;
        if (hs) begin
            w_tdata_d = {4'b0000, onehot, 1'b0, idx_q, wl.s_wtdata};
        end

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StArm;
                    err_d      = 1'b0;
                    err_code_d = 2'b00;
                    layer_d    = 2'd0;
                    idx_d      = 7'd0;
                end
            end
            StArm: begin
                if (abort) begin
                    state_d    = StDisarm;
                    err_d      = 1'b1;
                    err_code_d = 2'b11;
                end else begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (abort) begin
                    state_d    = StDisarm;
                    err_d      = 1'b1;
                    err_code_d = 2'b11;
                end else if (hs) begin
                    if (final_word) begin
                        state_d = StDisarm;
                        if (!wl.s_wtlast) begin
                            err_d      = 1'b1;
                            err_code_d = 2'b10;
                        end
                    end else if (wl.s_wtlast) begin
                        state_d    = StDisarm;
                        err_d      = 1'b1;
                        err_code_d = 2'b01;
                    end else if (idx_q == idx_lim) begin
                        idx_d   = 7'd0;
                        layer_d = layer_q + 2'd1;
                    end else begin
                        idx_d = idx_q + 7'd1;
                    end
                end
            end
            // err_q already reflects the outcome of the load by the time DISARM runs.
            StDisarm: state_d = err_q ? StIdle : StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        set_en   = 1'b0;
        set_in_d = set_in_q;
        if (state_q == StArm) begin
            set_en   = 1'b1;
            set_in_d = wl.set_cur | WrEnBit;
        end else if (state_q == StDisarm) begin
            set_en   = 1'b1;
            set_in_d = wl.set_cur & ~WrEnBit;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= StIdle;
            layer_q    <= 2'd0;
            idx_q      <= 7'd0;
            w_tdata_q  <= '0;
            set_in_q   <= '0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            layer_q    <= layer_d;
            idx_q      <= idx_d;
            w_tdata_q  <= w_tdata_d;
            set_in_q   <= set_in_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign wl.s_wtready = ready;
    assign wl.w_tdata   = w_tdata_q;
    assign wl.set_en    = set_en;
    assign wl.set_in    = set_in_d;
    assign busy         = (state_q != StIdle);
    assign done         = (state_q == StDone);
    assign act_enable   = (state_q == StIdle) || (state_q == StDone);
    assign err          = err_q;
    assign err_code     = err_code_q;

endmodule
